// File: rtl/sccb_init_sequencer.sv
// -----------------------------------------------------------------------------
// sccb_init_sequencer
//
// Plays back a camera-sensor register table over an AXI4 write channel. Each
// table entry {sub_addr, data} becomes one 2-beat write burst (sub_addr, then
// data) to the SCCB master's write-transfer register. Entry 16'hFFFF ends the
// table. An entry with sub_addr 8'hFE inserts a wait of data*DELAY_UNIT clocks
// instead of a bus write. A write that gets a bad response or a foreign ID is
// retried up to MAX_RETRY times. After that the sequencer stops and reports
// the failing index.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start_i             one-cycle pulse that starts playback from index 0
//   busy_o              playback in progress
//   done_o / err_o      sticky completion / failure flags, cleared by start_i
//   err_idx_o           table index of the entry that failed
//   rom_addr_o          table index, read data arrives one cycle later
//   rom_data_i          table entry {sub_addr[15:8], data[7:0]}
//   m_aw* / m_w* / m_b* AXI4 write address, write data and response channels
// -----------------------------------------------------------------------------
module sccb_init_sequencer #(
    parameter int                    DATA_W           = 8,
    parameter int                    ADDR_W           = 32,
    parameter int                    MST_ID_W         = 5,
    parameter int                    TRANS_DATA_LEN_W = 8,
    parameter int                    TRANS_RESP_W     = 2,
    parameter logic [ADDR_W-1:0]     SCCB_BASE_ADDR   = 32'h2000_0000,
    parameter logic [MST_ID_W-1:0]   MST_ID           = 5'd1,
    parameter int                    TBL_ADDR_W       = 8,
    parameter int                    DELAY_UNIT       = 1000,
    parameter int                    MAX_RETRY        = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic [TBL_ADDR_W-1:0]       err_idx_o,
    output logic [TBL_ADDR_W-1:0]       rom_addr_o,
    input  logic [15:0]                 rom_data_i,
    output logic [MST_ID_W-1:0]         m_awid_o,
    output logic [ADDR_W-1:0]           m_awaddr_o,
    output logic [TRANS_DATA_LEN_W-1:0] m_awlen_o,
    output logic                        m_awvalid_o,
    input  logic                        m_awready_i,
    output logic [DATA_W-1:0]           m_wdata_o,
    output logic                        m_wlast_o,
    output logic                        m_wvalid_o,
    input  logic                        m_wready_i,
    input  logic [MST_ID_W-1:0]         m_bid_i,
    input  logic [TRANS_RESP_W-1:0]     m_bresp_i,
    input  logic                        m_bvalid_i,
    output logic                        m_bready_o
);

    // Wide enough for the longest wait, 255 ticks.
    localparam int DLY_W   = $clog2(255 * DELAY_UNIT + 1);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, AW, W0, W1, BRESP, DELAY, DONE, ERR
    } state_t;

    state_t                  state_q,     state_d;
    logic [TBL_ADDR_W-1:0]   rom_addr_q,  rom_addr_d;
    logic [TBL_ADDR_W-1:0]   err_idx_q,   err_idx_d;
    logic [RETRY_W-1:0]      retry_q,     retry_d;
    logic [15:0]             entry_q,     entry_d;
    logic [DLY_W-1:0]        delay_cnt_q, delay_cnt_d;
    logic                    busy_q,      busy_d;
    logic                    done_q,      done_d;
    logic                    err_q,       err_d;
    logic                    awvalid_q,   awvalid_d;
    logic                    wvalid_q,    wvalid_d;
    logic [DATA_W-1:0]       wdata_q,     wdata_d;
    logic                    wlast_q,     wlast_d;
    logic                    bready_q,    bready_d;
    logic                    advance;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        err_idx_d   = err_idx_q;
        retry_d     = retry_q;
        entry_d     = entry_q;
        delay_cnt_d = delay_cnt_q;
        advance     = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    state_d    = FETCH;
                    rom_addr_d = '0;
                    retry_d    = '0;
                end
            end
            FETCH:  state_d = DECODE;   // the table read takes one cycle
            DECODE: begin
                entry_d = rom_data_i;
                if (rom_data_i == 16'hFFFF) begin
                    state_d = DONE;
                end else if (rom_data_i[15:8] == 8'hFE) begin
                    state_d     = DELAY;
                    delay_cnt_d = DLY_W'(rom_data_i[7:0]) * DLY_W'(DELAY_UNIT);
                end else begin
                    state_d = AW;
                end
            end
            AW:  if (m_awready_i) state_d = W0;
            W0:  if (m_wready_i)  state_d = W1;
            W1:  if (m_wready_i)  state_d = BRESP;
            BRESP: begin
                if (m_bvalid_i) begin
                    if (m_bresp_i == '0 && m_bid_i == MST_ID) begin
                        advance = 1'b1;
                    end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = AW;   // resend the same entry, already in entry_q
                    end else begin
                        err_idx_d = rom_addr_q;
                        state_d   = ERR;
                    end
                end
            end
            DELAY: begin
                // A zero count still spends one cycle here.
                if (delay_cnt_q <= DLY_W'(1)) begin
                    delay_cnt_d = '0;
                    advance     = 1'b1;
                end else begin
                    delay_cnt_d = delay_cnt_q - DLY_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The last index ends the table rather than wrapping to 0.
        if (advance) begin
            retry_d = '0;
            if (&rom_addr_q) begin
                state_d = DONE;
            end else begin
                rom_addr_d = rom_addr_q + TBL_ADDR_W'(1);
                state_d    = FETCH;
            end
        end

        // Outputs are decoded from the next state so they come straight from flops.
        busy_d    = !(state_d inside {IDLE, DONE, ERR});
        done_d    = (state_d == DONE);
        err_d     = (state_d == ERR);
        awvalid_d = (state_d == AW);
        wvalid_d  = (state_d == W0) || (state_d == W1);
        wlast_d   = (state_d == W1);
        bready_d  = (state_d == BRESP);
        wdata_d   = '0;
        if (state_d == W0) wdata_d = DATA_W'(entry_d[15:8]);
        if (state_d == W1) wdata_d = DATA_W'(entry_d[7:0]);
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before this edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rom_addr_q  <= '0;
            err_idx_q   <= '0;
            retry_q     <= '0;
            entry_q     <= '0;
            delay_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wdata_q     <= '0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            err_idx_q   <= err_idx_d;
            retry_q     <= retry_d;
            entry_q     <= entry_d;
            delay_cnt_q <= delay_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            wdata_q     <= wdata_d;
            wlast_q     <= wlast_d;
            bready_q    <= bready_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_idx_o   = err_idx_q;
    assign rom_addr_o  = rom_addr_q;
    assign m_awid_o    = MST_ID;
    assign m_awaddr_o  = SCCB_BASE_ADDR;
    assign m_awlen_o   = TRANS_DATA_LEN_W'(1);
    assign m_awvalid_o = awvalid_q;
    assign m_wdata_o   = wdata_q;
    assign m_wlast_o   = wlast_q;
    assign m_wvalid_o  = wvalid_q;
    assign m_bready_o  = bready_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sccb_init_sequencer
//
// Directed bench for sccb_init_sequencer. A synchronous table ROM and an AXI
// write slave are modelled here. The slave's ready stalls and response codes
// can be set per step. Every expected burst is pushed to a scoreboard before
// playback starts. Each completed burst pops one entry and is compared with it.
// -----------------------------------------------------------------------------
module tb_sccb_init_sequencer;

    localparam int DU        = 10;
    localparam int MAX_RETRY = 2;

    typedef struct {
        logic [7:0] sub;
        logic [7:0] data;
    } burst_t;

    typedef struct {
        logic [1:0] resp;
        logic [4:0] bid;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        busy_o, done_o, err_o;
    logic [7:0]  err_idx_o, rom_addr_o;
    logic [15:0] rom_q;
    logic [4:0]  m_awid_o;
    logic [31:0] m_awaddr_o;
    logic [7:0]  m_awlen_o;
    logic        m_awvalid_o, m_awready_i;
    logic [7:0]  m_wdata_o;
    logic        m_wlast_o, m_wvalid_o, m_wready_i;
    logic [4:0]  m_bid_i;
    logic [1:0]  m_bresp_i;
    logic        m_bvalid_i, m_bready_o;

    always #5 clk = ~clk;

    logic [15:0] rom [256];
    always @(posedge clk) rom_q <= rom[rom_addr_o];

    sccb_init_sequencer #(
        .DELAY_UNIT (DU),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .err_idx_o   (err_idx_o),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_q),
        .m_awid_o    (m_awid_o),
        .m_awaddr_o  (m_awaddr_o),
        .m_awlen_o   (m_awlen_o),
        .m_awvalid_o (m_awvalid_o),
        .m_awready_i (m_awready_i),
        .m_wdata_o   (m_wdata_o),
        .m_wlast_o   (m_wlast_o),
        .m_wvalid_o  (m_wvalid_o),
        .m_wready_i  (m_wready_i),
        .m_bid_i     (m_bid_i),
        .m_bresp_i   (m_bresp_i),
        .m_bvalid_i  (m_bvalid_i),
        .m_bready_o  (m_bready_o)
    );

    int          vec_cnt  = 0;
    int          miss_cnt = 0;
    burst_t      sb [$];
    rsp_t        rsp_q [$];

    int          aw_stall, w_stall, aw_wait, w_wait;
    bit          aw_stalled, w_stalled, b_pending, b_fire_prev;
    logic [44:0] aw_snap;
    logic [8:0]  w_snap;
    logic [7:0]  cur_sub;
    int          w_beat, aw_fires, w_fires, bursts, cyc_cnt, first_aw_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic slave_reset();
        aw_wait = 0; w_wait = 0; w_beat = 0;
        aw_stalled = 0; w_stalled = 0; b_pending = 0; b_fire_prev = 0;
        m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 0;
        m_bresp_i = 2'b00; m_bid_i = 5'd0;
        rsp_q.delete();
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    endtask

    task automatic push_exp(input logic [15:0] entry, input int times);
        burst_t b;
        b.sub  = entry[15:8];
        b.data = entry[7:0];
        for (int i = 0; i < times; i++) sb.push_back(b);
    endtask

    task automatic push_rsp(input logic [1:0] resp, input logic [4:0] bid);
        rsp_t r;
        r.resp = resp;
        r.bid  = bid;
        rsp_q.push_back(r);
    endtask

    // One clock of slave and monitor activity. It runs at the falling edge.
    // Readies are driven for the next rising edge before handshakes are judged.
    task automatic cycle();
        rsp_t   r;
        burst_t e;
        @(negedge clk);
        cyc_cnt++;
        if (rst) begin
            m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 0;
            return;
        end
        if (aw_stalled) begin
            check("aw_valid_hold", m_awvalid_o, 1);
            check("aw_payload_hold", {m_awaddr_o, m_awlen_o, m_awid_o}, aw_snap);
        end
        if (w_stalled) begin
            check("w_valid_hold", m_wvalid_o, 1);
            check("w_payload_hold", {m_wdata_o, m_wlast_o}, w_snap);
        end
        // Response channel: one response per completed burst.
        if (b_fire_prev) begin
            m_bvalid_i = 0;
            b_fire_prev = 0;
        end
        if (b_pending && !m_bvalid_i) begin
            if (rsp_q.size() != 0) r = rsp_q.pop_front();
            else begin r.resp = 2'b00; r.bid = 5'd1; end
            m_bresp_i  = r.resp;
            m_bid_i    = r.bid;
            m_bvalid_i = 1;
            b_pending  = 0;
        end
        if (m_bvalid_i && m_bready_o) b_fire_prev = 1;
        check("single_phase", int'(m_awvalid_o) + int'(m_wvalid_o) + int'(m_bready_o) <= 1, 1);
        // Address channel.
        m_awready_i = m_awvalid_o && (aw_wait >= aw_stall);
        aw_stalled  = m_awvalid_o && !m_awready_i;
        aw_snap     = {m_awaddr_o, m_awlen_o, m_awid_o};
        if (aw_stalled) aw_wait++;
        if (m_awvalid_o && m_awready_i) begin
            aw_fires++;
            aw_wait = 0;
            check("awaddr", m_awaddr_o, 32'h2000_0000);
            check("awlen", m_awlen_o, 8'd1);
            check("awid", m_awid_o, 5'd1);
            if (first_aw_cyc < 0) first_aw_cyc = cyc_cnt;
        end
        // Data channel.
        m_wready_i = m_wvalid_o && (w_wait >= w_stall);
        w_stalled  = m_wvalid_o && !m_wready_i;
        w_snap     = {m_wdata_o, m_wlast_o};
        if (w_stalled) w_wait++;
        if (m_wvalid_o && m_wready_i) begin
            w_fires++;
            w_wait = 0;
            check("wlast_on_beat", m_wlast_o, w_beat == 1);
            if (!m_wlast_o) begin
                cur_sub = m_wdata_o;
                w_beat  = 1;
            end else begin
                w_beat = 0;
                bursts++;
                check("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("burst_sub", cur_sub, e.sub);
                    check("burst_data", m_wdata_o, e.data);
                end
                b_pending = 1;
            end
        end
    endtask

    task automatic start_run();
        cyc_cnt = 0; first_aw_cyc = -1;
        aw_fires = 0; w_fires = 0; bursts = 0;
        start_i = 1;
        cycle();
        start_i = 0;
        check("busy_after_start", busy_o, 1);
        check("done_cleared", done_o, 0);
        check("err_cleared", err_o, 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            cycle();
            n++;
        end
        check("idle_within_budget", busy_o, 0);
    endtask

    initial begin
        rst = 1; start_i = 0; aw_stall = 0; w_stall = 0;
        slave_reset();
        clear_rom();
        repeat (3) cycle();
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_awvalid", m_awvalid_o, 0);
        check("rst_wvalid", m_wvalid_o, 0);
        check("rst_bready", m_bready_o, 0);
        check("rst_rom_addr", rom_addr_o, 0);
        check("rst_err_idx", err_idx_o, 0);
        rst = 0;
        cycle();

        // Two writes then end of table; start_i during playback is ignored.
        rom[0] = 16'h1280; rom[1] = 16'h3A04; rom[2] = 16'hFFFF;
        push_exp(16'h1280, 1); push_exp(16'h3A04, 1);
        start_run();
        repeat (3) cycle();
        start_i = 1; cycle(); start_i = 0;
        wait_idle(200);
        check("basic_done", done_o, 1);
        check("basic_err", err_o, 0);
        check("basic_bursts", bursts, 2);
        check("basic_sb_empty", sb.size(), 0);
        // FETCH and DECODE come before the first AW.
        check("basic_aw_latency", first_aw_cyc - 1, 2);

        // Delay entries: FETCH, DECODE, the wait, then FETCH and DECODE again.
        for (int k = 0; k < 2; k++) begin
            logic [7:0] ticks;
            ticks = (k == 0) ? 8'd3 : 8'd0;
            clear_rom();
            rom[0] = {8'hFE, ticks}; rom[1] = 16'h1280;
            push_exp(16'h1280, 1);
            start_run();
            wait_idle(400);
            check("delay_aw_latency", first_aw_cyc - 1,
                  4 + ((ticks == 0) ? 1 : int'(ticks) * DU));
            check("delay_done", done_o, 1);
            check("delay_bursts", bursts, 1);
        end

        // SLVERR on every try: initial write plus MAX_RETRY retries, then ERR.
        clear_rom();
        rom[0] = 16'h1280;
        for (int i = 0; i < 3; i++) push_rsp(2'b10, 5'd1);
        push_exp(16'h1280, MAX_RETRY + 1);
        start_run();
        wait_idle(300);
        check("slverr_err", err_o, 1);
        check("slverr_done", done_o, 0);
        check("slverr_idx", err_idx_o, 0);
        check("slverr_bursts", aw_fires, 3);
        check("slverr_sb_empty", sb.size(), 0);

        // A wrong response ID is retried and then succeeds.
        clear_rom();
        rom[0] = 16'h1280; rom[1] = 16'h3A04;
        push_rsp(2'b00, 5'd1); push_rsp(2'b00, 5'd2); push_rsp(2'b00, 5'd1);
        push_exp(16'h1280, 1); push_exp(16'h3A04, 2);
        start_run();
        wait_idle(300);
        check("badbid_done", done_o, 1);
        check("badbid_err", err_o, 0);
        check("badbid_bursts", bursts, 3);

        // Third entry gets DECERR, EXOKAY, SLVERR and fails at index 2.
        clear_rom();
        rom[0] = 16'h5511; rom[1] = 16'h6622; rom[2] = 16'h7733;
        push_rsp(2'b00, 5'd1); push_rsp(2'b00, 5'd1);
        push_rsp(2'b11, 5'd1); push_rsp(2'b01, 5'd1); push_rsp(2'b10, 5'd1);
        push_exp(16'h5511, 1); push_exp(16'h6622, 1); push_exp(16'h7733, 3);
        start_run();
        wait_idle(400);
        check("idx2_err", err_o, 1);
        check("idx2_err_idx", err_idx_o, 2);
        check("idx2_bursts", bursts, 5);

        // Slave holds ready low for 5 cycles on every channel beat.
        clear_rom();
        rom[0] = 16'h1280;
        aw_stall = 5; w_stall = 5;
        push_exp(16'h1280, 1);
        start_run();
        wait_idle(300);
        check("stall_aw_fires", aw_fires, 1);
        check("stall_w_fires", w_fires, 2);
        check("stall_done", done_o, 1);
        aw_stall = 0; w_stall = 0;

        // Full 256-entry table with no terminator stops at the last index.
        for (int i = 0; i < 256; i++) begin
            rom[i] = {8'(i % 200), 8'(i)};
            push_exp(rom[i], 1);
        end
        start_run();
        wait_idle(5000);
        check("full_done", done_o, 1);
        check("full_bursts", bursts, 256);
        check("full_rom_addr", rom_addr_o, 8'hFF);
        check("full_sb_empty", sb.size(), 0);

        // Reset while the last data beat is waiting for ready.
        clear_rom();
        rom[0] = 16'h1280; rom[1] = 16'h3A04;
        w_stall = 3;
        push_exp(16'h1280, 1);
        start_run();
        for (int n = 0; n < 50; n++) begin
            cycle();
            if (m_wvalid_o && m_wlast_o && !m_wready_i) break;
        end
        check("w1_reached", m_wvalid_o && m_wlast_o, 1);
        rst = 1;
        slave_reset();
        sb.delete();
        cycle();
        check("midrst_awvalid", m_awvalid_o, 0);
        check("midrst_wvalid", m_wvalid_o, 0);
        check("midrst_bready", m_bready_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_rom_addr", rom_addr_o, 0);
        rst = 0;
        w_stall = 0;
        cycle();
        push_exp(16'h1280, 1); push_exp(16'h3A04, 1);
        start_run();
        wait_idle(200);
        check("replay_done", done_o, 1);
        check("replay_bursts", bursts, 2);
        check("replay_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
